// File: rtl/event_conditioner.sv
// Button/select conditioner: synchronizes and debounces two raw inputs, then
// turns the debounced button into one-cycle count pulses with optional auto-repeat.

module event_conditioner_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic deb
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       s1;
  logic       s2;
  logic [7:0] cnt;

  // The level is accepted only after DEBOUNCE_CYCLES consecutive mismatching
  // samples; any agreeing sample restarts the count, for press and release alike.
  // NOTE: all state here is flops with a reset value; sequential logic uses
  // non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

module event_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8,
  parameter int AUTO_REPEAT     = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BtnRaw,
  input  logic SelRaw,
  output logic En,
  output logic Slt,
  output logic Held
);

  localparam logic [15:0] DELAY_LAST  = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  logic        deb_btn;
  logic        deb_sel;
  state_t      state;
  state_t      state_nxt;
  logic [15:0] timer;
  logic [15:0] timer_nxt;
  logic        en_nxt;

  event_conditioner_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_btn (
    .Clk  (Clk),
    .Reset(Reset),
    .raw  (BtnRaw),
    .deb  (deb_btn)
  );

  event_conditioner_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_sel (
    .Clk  (Clk),
    .Reset(Reset),
    .raw  (SelRaw),
    .deb  (deb_sel)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    en_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (deb_btn) begin
          state_nxt = HOLD;
          timer_nxt = '0;
          en_nxt    = 1'b1;
        end
      end
      HOLD: begin
        if (!deb_btn) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer == DELAY_LAST) begin
          // Without auto-repeat the timer parks here until release.
          if (AUTO_REPEAT != 0) begin
            state_nxt = REPEAT;
            timer_nxt = '0;
            en_nxt    = 1'b1;
          end
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      REPEAT: begin
        if (!deb_btn) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer == PERIOD_LAST) begin
          timer_nxt = '0;
          en_nxt    = 1'b1;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // Slt captures the pre-edge debounced select, so a select change landing on
  // a pulse edge only shows up on the following pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      timer <= '0;
      En    <= 1'b0;
      Slt   <= 1'b0;
      Held  <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      En    <= en_nxt;
      Held  <= (state_nxt == REPEAT);
      if (en_nxt) begin
        Slt <= deb_sel;
      end
    end
  end

endmodule

// File: tb/tb_event_conditioner.sv
// Directed bench for event_conditioner: default instance plus a no-repeat
// instance sharing the same raw inputs, edges counted from the first sampling edge.

module tb_event_conditioner;

  logic Clk    = 1'b0;
  logic Reset  = 1'b1;
  logic BtnRaw = 1'b0;
  logic SelRaw = 1'b0;
  logic en, slt, held;
  logic en_nr, slt_nr, held_nr;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  event_conditioner dut (
    .Clk   (Clk),
    .Reset (Reset),
    .BtnRaw(BtnRaw),
    .SelRaw(SelRaw),
    .En    (en),
    .Slt   (slt),
    .Held  (held)
  );

  event_conditioner #(
    .AUTO_REPEAT(0)
  ) dut_nr (
    .Clk   (Clk),
    .Reset (Reset),
    .BtnRaw(BtnRaw),
    .SelRaw(SelRaw),
    .En    (en_nr),
    .Slt   (slt_nr),
    .Held  (held_nr)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // Reset state
    #3 Reset = 1'b0;
    #1;
    check("rst_async en", en, 1'b0);
    check("rst_async held", held, 1'b0);
    idle(2);
    check("rst en", en, 1'b0);
    check("rst slt", slt, 1'b0);
    check("rst held", held, 1'b0);
    check("rst en_nr", en_nr, 1'b0);
    check("rst slt_nr", slt_nr, 1'b0);
    check("rst held_nr", held_nr, 1'b0);
    #3 Reset = 1'b1;
    idle(3);

    // Short press of 10 cycles, select low: single pulse at edge 6
    for (int e = 0; e < 26; e++) begin
      BtnRaw = (e < 10);
      tick();
      check($sformatf("short en e=%0d", e), en, e == 6);
      check($sformatf("short en_nr e=%0d", e), en_nr, e == 6);
      check($sformatf("short held e=%0d", e), held, 1'b0);
      if (e == 6) check("short slt", slt, 1'b0);
    end
    idle(5);

    // Glitch of 3 cycles: rejected
    for (int e = 0; e < 20; e++) begin
      BtnRaw = (e < 3);
      tick();
      check($sformatf("glitch en e=%0d", e), en, 1'b0);
      check($sformatf("glitch en_nr e=%0d", e), en_nr, 1'b0);
    end
    idle(5);

    // Long press with select high: auto-repeat train and Held window
    SelRaw = 1'b1;
    idle(10);
    for (int e = 0; e < 76; e++) begin
      BtnRaw = (e < 60);
      tick();
      check($sformatf("rep en e=%0d", e), en,
            e inside {6, 22, 30, 38, 46, 54, 62});
      check($sformatf("rep held e=%0d", e), held, (e >= 22) && (e <= 65));
      check($sformatf("rep en_nr e=%0d", e), en_nr, e == 6);
      check($sformatf("rep held_nr e=%0d", e), held_nr, 1'b0);
      if (e inside {6, 22, 30, 38, 46, 54, 62})
        check($sformatf("rep slt e=%0d", e), slt, 1'b1);
      if (e == 6) check("rep slt_nr", slt_nr, 1'b1);
    end
    SelRaw = 1'b0;
    idle(10);

    // Reset at edge 25 of a held press, released before edge 30
    for (int e = 0; e < 25; e++) begin
      BtnRaw = 1'b1;
      tick();
      check($sformatf("mrst en e=%0d", e), en, e inside {6, 22});
      check($sformatf("mrst held e=%0d", e), held, e >= 22);
      check($sformatf("mrst en_nr e=%0d", e), en_nr, e == 6);
    end
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("mrst async held", held, 1'b0);
    check("mrst async en", en, 1'b0);
    for (int e = 26; e < 30; e++) begin
      tick();
      check($sformatf("mrst low en e=%0d", e), en, 1'b0);
      check($sformatf("mrst low held e=%0d", e), held, 1'b0);
    end
    #3 Reset = 1'b1;
    for (int e = 30; e < 46; e++) begin
      tick();
      check($sformatf("mrst rel en e=%0d", e), en, e == 36);
      check($sformatf("mrst rel en_nr e=%0d", e), en_nr, e == 36);
      check($sformatf("mrst rel held e=%0d", e), held, 1'b0);
    end
    BtnRaw = 1'b0;
    idle(12);

    // Select debounce completes on the edge of the repeat pulse at 30
    for (int e = 0; e < 41; e++) begin
      BtnRaw = 1'b1;
      SelRaw = (e >= 25);
      tick();
      check($sformatf("sel en e=%0d", e), en, e inside {6, 22, 30, 38});
      if (e == 22) check("sel slt e=22", slt, 1'b0);
      if (e == 30) check("sel slt e=30", slt, 1'b0);
      if (e == 38) check("sel slt e=38", slt, 1'b1);
    end
    BtnRaw = 1'b0;
    SelRaw = 1'b0;
    idle(12);

    // Reset dropped mid-cycle while En is high
    for (int e = 0; e < 7; e++) begin
      BtnRaw = 1'b1;
      tick();
    end
    check("pulse en before rst", en, 1'b1);
    #2 Reset = 1'b0;
    #1;
    check("pulse en async", en, 1'b0);
    check("pulse en_nr async", en_nr, 1'b0);
    idle(2);
    BtnRaw = 1'b0;
    #3 Reset = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      check($sformatf("post rst en e=%0d", e), en, 1'b0);
    end

    // Select activity alone never produces En
    for (int e = 0; e < 30; e++) begin
      SelRaw = ((e / 3) % 2) == 1;
      tick();
      check($sformatf("selonly en e=%0d", e), en, 1'b0);
      check($sformatf("selonly en_nr e=%0d", e), en_nr, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/event_conditioner.md
EVENT_CONDITIONER -- requirements
Module: event_conditioner

Interface
REQ-001 The block SHALL have a parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable cycles needed to accept a level change (legal range 1..255).
REQ-002 The block SHALL have a parameter REPEAT_DELAY, default 16, giving the cycles from accepted press to first auto-repeat pulse (legal range 2..65535).
REQ-003 The block SHALL have a parameter REPEAT_PERIOD, default 8, giving the cycles between auto-repeat pulses (legal range 2..65535).
REQ-004 The block SHALL have a parameter AUTO_REPEAT, default 1; value 1 enables auto-repeat, value 0 gives a single pulse per press.
REQ-005 Clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset; Reset=0 clears all state immediately.
REQ-007 BtnRaw  input  1  raw, asynchronous, bouncy count button.
REQ-008 SelRaw  input  1  raw, asynchronous, bouncy select switch.
REQ-009 En  output  1  registered one-cycle event pulse for the downstream counter.
REQ-010 Slt  output  1  registered select qualifier, valid whenever En=1.
REQ-011 Held  output  1  registered; 1 while the FSM is in REPEAT.

Function
REQ-012 Each raw input SHALL pass through its own 2-flop synchronizer (s1, then s2) before any other logic.
REQ-013 Each synchronized input SHALL have a debounced level register deb and a counter.
- Edge where s2 != deb: counter increments.
- Edge where s2 == deb: counter clears to 0.
- When the counter equals DEBOUNCE_CYCLES-1 on a mismatch edge: deb <= s2 and the counter clears.
REQ-014 Latency: BtnRaw held at 1 from edge 0 (first sampling edge) SHALL give debBtn=1 after edge 1+DEBOUNCE_CYCLES and En=1 for exactly the cycle after edge 2+DEBOUNCE_CYCLES.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change deb and SHALL NOT produce En.
REQ-016 The FSM SHALL have states IDLE, HOLD and REPEAT, plus a 16-bit timer.
- IDLE -> HOLD on a debBtn rising: emit En, clear the timer.
- HOLD: timer increments each cycle. At timer==REPEAT_DELAY-1 with AUTO_REPEAT=1: emit En, clear the timer, go to REPEAT. With AUTO_REPEAT=0: stay in HOLD, timer saturates.
- REPEAT: timer increments. At timer==REPEAT_PERIOD-1: emit En, clear the timer.
- Any state -> IDLE when debBtn=0, with no En that cycle.
REQ-017 En SHALL never be high on two consecutive cycles, and SHALL be 0 whenever the FSM is IDLE.
REQ-018 Slt SHALL be loaded with the current debSel value (value before any same-edge update) on every edge that sets En=1, and SHALL hold otherwise.
REQ-019 A debSel change on the same edge as an En-setting edge SHALL take effect only from the next pulse.
REQ-020 SelRaw activity without a button event SHALL NOT produce En.
REQ-021 The release debounce (deb 1 -> 0) SHALL use the same DEBOUNCE_CYCLES rule as the press debounce.
REQ-022 Held SHALL be 1 exactly while the state register is REPEAT.

Reset
REQ-023 While Reset=0, all of the following SHALL be 0: s1, s2, deb, counters, timer, En, Slt, Held; the state SHALL be IDLE.
REQ-024 Reset asserted mid-press or mid-repeat SHALL remove En within the same cycle (asynchronously), with no partial pulse after release.
REQ-025 If BtnRaw is still high at reset release, it SHALL be treated as a new press: one En at edge 2+DEBOUNCE_CYCLES after the first sampling edge.

Verification
REQ-026 Defaults, BtnRaw 0->1 held for 10 cycles, SelRaw=0 -> single En pulse after edge 6 with Slt=0, Held=0.
REQ-027 BtnRaw high for 3 cycles, then low -> no En; debBtn stays 0.
REQ-028 SelRaw=1 stable, BtnRaw held 60 cycles -> En pulses at edges 6, 22, 30, 38, 46, 54, 62 (relative to first sampling edge), all with Slt=1; Held=1 from edge 22 until debounced release.
REQ-029 AUTO_REPEAT=0, BtnRaw held 60 cycles -> exactly one En; Held stays 0.
REQ-030 Reset driven low at edge 25 of a held press, released at edge 30, BtnRaw still high -> En=0 from Reset fall, next En after edge 36.
REQ-031 SelRaw toggles to 1 so that debSel rises on the same edge as a repeat pulse -> that pulse has Slt=0, the following pulse has Slt=1.
